// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue: FSM states,
// queue entry layout and word-address arithmetic.
package if_prefetch_queue_pkg;

  localparam int WORD_BYTES = 4;
  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 32;

  typedef enum logic {
    PFQ_RUN   = 1'b0,
    PFQ_DRAIN = 1'b1
  } pfq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } pfq_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^32 by construction.
  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// DEPTH x {addr,instr} FIFO: synchronous write, asynchronous head read,
// push/pop/flush with occupancy count. Flush wins over push and pop.
module if_prefetch_queue_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  pfq_entry_t    wr_entry,
  output pfq_entry_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  pfq_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_entry;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch front end: runs sequential fetches ahead of the core,
// serves hits from a small queue and flushes/refetches on any redirect.
// Optional PFQ_BYPASS_EN lets a word acked into an empty queue go straight to ir.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter  int          DEPTH      = 4,
  parameter  logic [31:0] RESET_ADDR = 32'h0000_0000,
  localparam int          CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic [31:0]   core_addr,
  output logic [31:0]   ir,
  output logic          ir_valid,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output pfq_state_e    dbg_state,
  output logic [CW-1:0] dbg_count
);

  // Memory handshake: mem_req rises with a stable mem_addr and stays high up to
  // and including the single mem_ack cycle; an ack seen with mem_req=0 is
  // stale (e.g. across a reset) and ignored. Core side: a cycle with core_req=1
  // and ir_valid=1 consumes the instruction.

  pfq_state_e     state, state_nxt;
  logic [31:0]    exp_addr, exp_nxt;
  logic [31:0]    fetch_addr, fetch_nxt;
  logic           mem_req_nxt;
  logic [31:0]    mem_addr_nxt;
  logic [31:0]    req_addr;
  logic           ack_take;
  logic           redirect;
  logic           q_hit;
  logic           bypass_hit;
  logic           issue;
  logic           push;
  pfq_entry_t     head;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  assign req_addr = word_align(core_addr);
  assign ack_take = mem_req && mem_ack;
  assign redirect = core_req && (req_addr != exp_addr);
  assign q_hit    = core_req && !redirect && !empty && (req_addr == head.addr);

`ifdef PFQ_BYPASS_EN
  assign bypass_hit = core_req && !redirect && empty && (state == PFQ_RUN)
                      && ack_take && (req_addr == mem_addr);
  assign ir         = bypass_hit ? mem_rdata : (q_hit ? head.data : '0);
`else
  assign bypass_hit = 1'b0;
  assign ir         = q_hit ? head.data : '0;
`endif

  assign ir_valid = q_hit || bypass_hit;

  // With at most one request in flight, "count+pending<DEPTH" reduces to !full
  // once mem_req is low. No issue on a redirect cycle: fetch_addr is stale.
  assign issue = (state == PFQ_RUN) && !mem_req && !full && !redirect;
  assign push  = ack_take && (state == PFQ_RUN) && !redirect && !bypass_hit;

  if_prefetch_queue_fifo #(.DEPTH(DEPTH)) u_pfq_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (q_hit),
    .flush    (redirect),
    .wr_entry ({mem_addr, mem_rdata}),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PFQ_RUN;
      exp_addr   <= RESET_ADDR;
      fetch_addr <= RESET_ADDR;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_nxt;
      exp_addr   <= exp_nxt;
      fetch_addr <= fetch_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    exp_nxt      = exp_addr;
    fetch_nxt    = fetch_addr;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;

    case (state)
      PFQ_RUN:   if (redirect && mem_req && !mem_ack) state_nxt = PFQ_DRAIN;
      PFQ_DRAIN: if (ack_take) state_nxt = PFQ_RUN;
      default:   state_nxt = PFQ_RUN;
    endcase

    if (ack_take) mem_req_nxt = 1'b0;
    if (issue) begin
      mem_req_nxt  = 1'b1;
      mem_addr_nxt = fetch_addr;
      fetch_nxt    = next_word(fetch_addr);
    end

    if (redirect) begin
      exp_nxt   = req_addr;
      fetch_nxt = req_addr;
    end else if (q_hit || bypass_hit) begin
      exp_nxt = next_word(exp_addr);
    end
  end

  assign dbg_state = state;
  assign dbg_count = count;

endmodule
